// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared DHT11 timing constants, state encoding and frame helpers
package dht11_pkg;

    // Default protocol timing in 1 us clock cycles
    localparam int START_MIN_DEF = 18000;
    localparam int RESP_WAIT_DEF = 30;
    localparam int RESP_LOW_DEF  = 80;
    localparam int RESP_HIGH_DEF = 80;
    localparam int BIT_LOW_DEF   = 50;
    localparam int BIT0_HIGH_DEF = 26;
    localparam int BIT1_HIGH_DEF = 70;
    localparam int END_LOW_DEF   = 50;

    localparam int FRAME_BITS = 40;
    localparam int LOW_CNT_W  = 19;
    localparam int BIT_CNT_W  = 6;
    localparam int PHASE_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_REL  = 3'd1,
        ST_RESP_LOW  = 3'd2,
        ST_RESP_HIGH = 3'd3,
        ST_BIT_LOW   = 3'd4,
        ST_BIT_HIGH  = 3'd5,
        ST_END_LOW   = 3'd6
    } dht11_state_e;

    // Checksum is the plain byte sum truncated to 8 bits
    function automatic logic [7:0] dht11_checksum(
        input logic [7:0] hum_int,
        input logic [7:0] hum_dec,
        input logic [7:0] temp_int,
        input logic [7:0] temp_dec
    );
        logic [7:0] sum;
        sum = hum_int + hum_dec + temp_int + temp_dec;
        return sum;
    endfunction

    // Frame as transmitted MSB first
    function automatic logic [FRAME_BITS-1:0] dht11_frame(
        input logic [7:0] hum_int,
        input logic [7:0] hum_dec,
        input logic [7:0] temp_int,
        input logic [7:0] temp_dec
    );
        return {hum_int, hum_dec, temp_int, temp_dec,
                dht11_checksum(hum_int, hum_dec, temp_int, temp_dec)};
    endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// rtl/dht11_responder_if.sv - reported values and status of the DHT11 responder
interface dht11_responder_if;

    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       busy;
    logic       frame_done;

    // Side that supplies the values and watches frame status
    modport master (
        output hum_int, hum_dec, temp_int, temp_dec,
        input  busy, frame_done
    );

    // Responder side
    modport slave (
        input  hum_int, hum_dec, temp_int, temp_dec,
        output busy, frame_done
    );

endinterface

// File: rtl/dht11_sync2.sv
// rtl/dht11_sync2.sv - two-flop synchronizer for the idle-high data line
module dht11_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Two stages, reset to the released (high) level so reset never looks like a start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor emulator driving response preamble and 40-bit frame
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int START_MIN = START_MIN_DEF,
    parameter int RESP_WAIT = RESP_WAIT_DEF,
    parameter int RESP_LOW  = RESP_LOW_DEF,
    parameter int RESP_HIGH = RESP_HIGH_DEF,
    parameter int BIT_LOW   = BIT_LOW_DEF,
    parameter int BIT0_HIGH = BIT0_HIGH_DEF,
    parameter int BIT1_HIGH = BIT1_HIGH_DEF,
    parameter int END_LOW   = END_LOW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               dht_data,
    dht11_responder_if.slave  bus
);

    localparam logic [LOW_CNT_W-1:0] START_MIN_C = LOW_CNT_W'(START_MIN);
    localparam logic [PHASE_W-1:0]   WAIT_LAST   = PHASE_W'(RESP_WAIT - 1);
    localparam logic [PHASE_W-1:0]   RLOW_LAST   = PHASE_W'(RESP_LOW - 1);
    localparam logic [PHASE_W-1:0]   RHIGH_LAST  = PHASE_W'(RESP_HIGH - 1);
    localparam logic [PHASE_W-1:0]   BLOW_LAST   = PHASE_W'(BIT_LOW - 1);
    localparam logic [PHASE_W-1:0]   B0_LAST     = PHASE_W'(BIT0_HIGH - 1);
    localparam logic [PHASE_W-1:0]   B1_LAST     = PHASE_W'(BIT1_HIGH - 1);
    localparam logic [PHASE_W-1:0]   ELOW_LAST   = PHASE_W'(END_LOW - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(FRAME_BITS - 1);

    dht11_state_e            r_state;
    logic                    r_oe;
    logic                    r_busy;
    logic                    r_frame_done;
    logic [LOW_CNT_W-1:0]    r_low_cnt;
    logic [PHASE_W-1:0]      r_phase;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [FRAME_BITS-1:0]   r_shift;

    logic                    w_line_s;
    logic [PHASE_W-1:0]      w_phase_last;
    logic                    w_phase_done;

    // Open drain: only ever pull low, the pull-up is off-chip
    assign dht_data = r_oe ? 1'b0 : 1'bz;

    dht11_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (dht_data),
        .o_q (w_line_s)
    );

    // Last phase-counter value of the current state; data-high length follows the current MSB
    always_comb begin
        w_phase_last = '0;
        unique case (r_state)
            ST_WAIT_REL:  w_phase_last = WAIT_LAST;
            ST_RESP_LOW:  w_phase_last = RLOW_LAST;
            ST_RESP_HIGH: w_phase_last = RHIGH_LAST;
            ST_BIT_LOW:   w_phase_last = BLOW_LAST;
            ST_BIT_HIGH:  w_phase_last = r_shift[FRAME_BITS-1] ? B1_LAST : B0_LAST;
            ST_END_LOW:   w_phase_last = ELOW_LAST;
            default:      w_phase_last = '0;
        endcase
    end

    assign w_phase_done = (r_phase == w_phase_last);

    // Main protocol FSM with registered line enable and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_oe         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_low_cnt    <= '0;
            r_phase      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!w_line_s) begin
                        if (r_low_cnt != '1) begin
                            r_low_cnt <= r_low_cnt + 1'b1;
                        end
                    end else begin
                        r_low_cnt <= '0;
                        if (r_low_cnt >= START_MIN_C) begin
                            // Values are frozen here; later input changes cannot alter this frame
                            r_state   <= ST_WAIT_REL;
                            r_busy    <= 1'b1;
                            r_phase   <= '0;
                            r_bit_cnt <= '0;
                            r_shift   <= dht11_frame(bus.hum_int, bus.hum_dec,
                                                     bus.temp_int, bus.temp_dec);
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (w_phase_done) begin
                        r_state <= ST_RESP_LOW;
                        r_oe    <= 1'b1;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_RESP_LOW: begin
                    if (w_phase_done) begin
                        r_state <= ST_RESP_HIGH;
                        r_oe    <= 1'b0;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_RESP_HIGH: begin
                    if (w_phase_done) begin
                        r_state <= ST_BIT_LOW;
                        r_oe    <= 1'b1;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_BIT_LOW: begin
                    if (w_phase_done) begin
                        r_state <= ST_BIT_HIGH;
                        r_oe    <= 1'b0;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_BIT_HIGH: begin
                    if (w_phase_done) begin
                        r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_oe      <= 1'b1;
                        r_phase   <= '0;
                        r_state   <= (r_bit_cnt == LAST_BIT) ? ST_END_LOW : ST_BIT_LOW;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_END_LOW: begin
                    if (w_phase_done) begin
                        r_state      <= ST_IDLE;
                        r_oe         <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_low_cnt    <= '0;
                        r_phase      <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - scoreboard bench for the DHT11 responder
`timescale 1ns/1ps
module tb_dht11_responder;

    localparam int START_MIN = 300;
    localparam int RESP_WAIT = 30;
    localparam int RUN_MAX   = 400;
    localparam int WAIT_MAX  = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_low = 1'b0;
    logic mon_en = 1'b1;
    wire  dht_data;

    pullup (dht_data);
    assign dht_data = host_low ? 1'b0 : 1'bz;

    dht11_responder_if bus ();

    dht11_responder #(.START_MIN(START_MIN)) dut (
        .clk      (clk),
        .rst      (rst),
        .dht_data (dht_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int release_cyc = 0;
    int fall_cnt = 0;
    int frames_seen = 0;
    logic [39:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    function automatic bit line_hi();
        return (dht_data === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    // Reference: bytes in transmit order followed by their sum modulo 256
    function automatic logic [39:0] model_frame(input int h, input int hd, input int t, input int td);
        longint f;
        f = (longint'(h) * 2**32) + (longint'(hd) * 2**24) + (longint'(t) * 2**16)
            + (longint'(td) * 2**8) + longint'((h + hd + t + td) % 256);
        return f[39:0];
    endfunction

    task automatic run_len(input bit lvl, output int n);
        n = 0;
        while (line_hi() == lvl && n < RUN_MAX) begin
            n++;
            sample();
        end
    endtask

    task automatic decode_frame();
        logic [39:0] exp;
        logic [39:0] got;
        int n;
        int bad_low;
        int bad_high;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check("release_to_response", cyc - release_cyc, RESP_WAIT + 3);
        check("busy_in_frame", bus.busy, 1);
        run_len(1'b0, n); check("resp_low_len", n, 80);
        run_len(1'b1, n); check("resp_high_len", n, 80);
        bad_low = 0; bad_high = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            run_len(1'b0, n);
            if (n != 50) bad_low++;
            run_len(1'b1, n);
            got = {got[38:0], (n > 48)};
            if (n != (exp[39-i] ? 70 : 26)) bad_high++;
        end
        check("bit_low_slots_wrong", bad_low, 0);
        check("bit_high_widths_wrong", bad_high, 0);
        check("frame_data", got, exp);
        run_len(1'b0, n); check("end_low_len", n, 50);
        check("frame_done_pulse", bus.frame_done, 1);
        check("busy_after_frame", bus.busy, 0);
        sample();
        check("frame_done_one_cycle", bus.frame_done, 0);
        frames_seen++;
    endtask

    // Monitor: decode every responder-driven frame and score it against the queue
    initial begin
        forever begin
            sample();
            if (mon_en && !host_low && dht_data === 1'b0 && !rst) decode_frame();
        end
    end

    // Count responder-driven falling edges to locate bit slots
    initial begin
        bit prev = 1'b1;
        bit cur;
        forever begin
            sample();
            cur = line_hi();
            if (prev && !cur && !host_low) fall_cnt++;
            prev = cur;
        end
    end

    task automatic set_inputs(input int h, input int hd, input int t, input int td);
        bus.hum_int = 8'(h); bus.hum_dec = 8'(hd); bus.temp_int = 8'(t); bus.temp_dec = 8'(td);
    endtask

    task automatic issue(input int h, input int hd, input int t, input int td);
        @(negedge clk);
        set_inputs(h, hd, t, td);
        exp_q.push_back(model_frame(h, hd, t, td));
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        host_low = 1'b1;
        repeat (len) @(negedge clk);
        host_low = 1'b0;
        release_cyc = cyc;
    endtask

    task automatic wait_frames(input int target);
        for (int k = 0; k < WAIT_MAX && frames_seen < target; k++) sample();
        check("frame_count_timeout", frames_seen, target);
    endtask

    task automatic wait_fall(input int target);
        for (int k = 0; k < WAIT_MAX && fall_cnt < target; k++) sample();
        check("fall_wait_timeout", fall_cnt >= target, 1);
    endtask

    task automatic rand_frame(input int target);
        issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        do_start(START_MIN);
        wait_frames(target);
    endtask

    initial begin
        int base;
        int bad;
        set_inputs(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        sample();
        check("reset_busy", bus.busy, 0);
        check("reset_frame_done", bus.frame_done, 0);
        check("reset_line_released", line_hi(), 1);
        @(negedge clk);
        rst = 1'b0;

        // Reference frame at exactly the minimum start length
        issue(8'h37, 8'h00, 8'h18, 8'h00);
        do_start(START_MIN);
        wait_frames(1);

        // One cycle short of a valid start
        do_start(START_MIN - 1);
        bad = 0;
        repeat (10000) begin
            sample();
            if (!line_hi() || bus.busy) bad++;
        end
        check("short_start_ignored", bad, 0);

        // Checksum wrap
        issue(8'hFF, 8'hFF, 8'h01, 8'h02);
        do_start(START_MIN);
        wait_frames(2);

        // Inputs change during bit 5; frame must carry the snapshot
        base = fall_cnt;
        issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        do_start(START_MIN);
        wait_fall(base + 7);
        @(negedge clk);
        set_inputs(8'hAA, 8'hAA, 8'hAA, 8'hAA);
        wait_frames(3);

        // Reset during bit 20 aborts silently
        mon_en = 1'b0;
        base = fall_cnt;
        set_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        do_start(START_MIN);
        wait_fall(base + 22);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        sample();
        check("midframe_rst_line", line_hi(), 1);
        check("midframe_rst_busy", bus.busy, 0);
        check("midframe_rst_done", bus.frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (200) begin
            sample();
            if (!line_hi() || bus.busy || bus.frame_done) bad++;
        end
        check("after_rst_quiet", bad, 0);
        mon_en = 1'b1;
        rand_frame(4);

        // Back-to-back frames with a host pulse inside the first
        base = fall_cnt;
        issue($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        do_start(START_MIN);
        wait_fall(base + 1);
        repeat (10) @(negedge clk);
        host_low = 1'b1;
        repeat (30) @(negedge clk);
        host_low = 1'b0;
        bad = 1;
        for (int k = 0; k < WAIT_MAX && bad != 0; k++) begin
            sample();
            if (bus.frame_done) bad = 0;
        end
        check("b2b_first_done_timeout", bad, 0);
        exp_q.push_back(model_frame($urandom_range(0, 255), 8'h5A, 8'h00, 8'hC3));
        set_inputs(exp_q[exp_q.size()-1][39:32], 8'h5A, 8'h00, 8'hC3);
        do_start(START_MIN);
        wait_frames(6);

        // Further random frames
        for (int i = 0; i < 2; i++) rand_frame(7 + i);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
